alu_arbiter: RTL and testbench

Shares one combinational `ALU` instance between two requesters, for example the pipeline EX stage (port 0) and a multi-cycle unit or debug port (port 1). Each request uses a valid/ready handshake. A round-robin arbiter picks at most one requester per cycle and drives that requester's operands into the ALU. The result, overflow and an unsupported-code error flag are registered into a per-requester response slot that holds until the requester accepts it.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/ALU.sv | 41 ++++
 rtl/alu_arbiter.sv | 89 ++++++++
 tb/tb_alu_arbiter.sv | 386 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: ALUCode values shared by the ALU, the arbiter and their benches.
package alu_pkg;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_AND  = 5'd1;
    localparam logic [4:0] ALU_XOR  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_NOR  = 5'd4;
    localparam logic [4:0] ALU_SUB  = 5'd5;
    localparam logic [4:0] ALU_ANDI = 5'd6;
    localparam logic [4:0] ALU_XORI = 5'd7;
    localparam logic [4:0] ALU_ORI  = 5'd8;
    localparam logic [4:0] ALU_SLL  = 5'd16;
    localparam logic [4:0] ALU_SRL  = 5'd17;
    localparam logic [4:0] ALU_SRA  = 5'd18;
    localparam logic [4:0] ALU_SLT  = 5'd19;
    localparam logic [4:0] ALU_SLTU = 5'd20;

    function automatic logic code_supported(input logic [4:0] code);
        return code inside {ALU_ADD, ALU_AND, ALU_XOR, ALU_OR, ALU_NOR, ALU_SUB, ALU_ANDI,
                            ALU_XORI, ALU_ORI, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU};
    endfunction
endpackage

// File: rtl/ALU.sv
// ALU: 32-bit combinational ALU; shifts take the amount from A[4:0], unsupported codes yield 0.
module ALU
    import alu_pkg::*;
(
    output logic [31:0] Result,
    output logic        overflow,
    input  logic [4:0]  ALUCode,
    input  logic [31:0] A,
    input  logic [31:0] B
);
    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = A + B;
    assign diff = A - B;

    always_comb begin
        Result   = '0;
        overflow = 1'b0;
        case (ALUCode)
            ALU_ADD: begin
                Result   = sum;
                overflow = (A[31] == B[31]) && (sum[31] != A[31]);
            end
            ALU_SUB: begin
                Result   = diff;
                overflow = (A[31] != B[31]) && (diff[31] != A[31]);
            end
            ALU_AND, ALU_ANDI: Result = A & B;
            ALU_XOR, ALU_XORI: Result = A ^ B;
            ALU_OR, ALU_ORI:   Result = A | B;
            ALU_NOR:           Result = ~(A | B);
            ALU_SLL:           Result = B << A[4:0];
            ALU_SRL:           Result = B >> A[4:0];
            ALU_SRA:           Result = $signed(B) >>> A[4:0];
            ALU_SLT:           Result = {31'd0, $signed(A) < $signed(B)};
            ALU_SLTU:          Result = {31'd0, A < B};
            default:           Result = '0;
        endcase
    end
endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two valid/ready requesters,
// with a registered response slot per requester.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CODE_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [CODE_W-1:0] req0_code,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [CODE_W-1:0] req1_code,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic [DATA_W-1:0] rsp0_result,
    output logic              rsp0_overflow,
    output logic              rsp0_err,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp1_result,
    output logic              rsp1_overflow,
    output logic              rsp1_err
);
    logic              last;
    logic              elig0, elig1;
    logic [CODE_W-1:0] code;
    logic [DATA_W-1:0] a, b, result;
    logic              overflow, err;

    // A slot draining this cycle may be refilled in the same cycle.
    assign elig0 = rst_n & req0_valid & (~rsp0_valid | rsp0_ready);
    assign elig1 = rst_n & req1_valid & (~rsp1_valid | rsp1_ready);
    assign req0_ready = elig0 & (~elig1 | last);
    assign req1_ready = elig1 & (~elig0 | ~last);

    assign code = req1_ready ? req1_code : req0_code;
    assign a    = req1_ready ? req1_a    : req0_a;
    assign b    = req1_ready ? req1_b    : req0_b;
    assign err  = ~code_supported(code);

    ALU u_alu (
        .Result  (result),
        .overflow(overflow),
        .ALUCode (code),
        .A       (a),
        .B       (b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last          <= 1'b1;
            rsp0_valid    <= 1'b0;
            rsp0_result   <= '0;
            rsp0_overflow <= 1'b0;
            rsp0_err      <= 1'b0;
            rsp1_valid    <= 1'b0;
            rsp1_result   <= '0;
            rsp1_overflow <= 1'b0;
            rsp1_err      <= 1'b0;
        end else begin
            if (req0_ready | req1_ready)
                last <= req1_ready;
            if (req0_ready) begin
                rsp0_valid    <= 1'b1;
                rsp0_result   <= result;
                rsp0_overflow <= overflow;
                rsp0_err      <= err;
            end else if (rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (req1_ready) begin
                rsp1_valid    <= 1'b1;
                rsp1_result   <= result;
                rsp1_overflow <= overflow;
                rsp1_err      <= err;
            end else if (rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed scenarios plus a random run, with a grant/slot model and response scoreboard.
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        logic [31:0] result;
        logic        ovf;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]  req0_code, req1_code;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_overflow, rsp1_overflow, rsp0_err, rsp1_err;

    int   checks = 0;
    int   failures = 0;
    rsp_t q0[$];
    rsp_t q1[$];
    rsp_t exp_head;
    logic m_last, m_v0, m_v1, e0, e1, g0, g1;

    always #5 clk = ~clk;

    alu_arbiter #(.DATA_W(32), .CODE_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_code(req0_code),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_code(req1_code),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
        .rsp0_overflow(rsp0_overflow), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
        .rsp1_overflow(rsp1_overflow), .rsp1_err(rsp1_err)
    );

    function automatic rsp_t model(input logic [4:0] c, input logic [31:0] a, input logic [31:0] b);
        rsp_t r;
        logic [32:0] w;
        r = '0;
        case (c)
            5'd0: begin
                w = {a[31], a} + {b[31], b};
                r.result = w[31:0];
                r.ovf = w[32] ^ w[31];
            end
            5'd5: begin
                w = {a[31], a} - {b[31], b};
                r.result = w[31:0];
                r.ovf = w[32] ^ w[31];
            end
            5'd1, 5'd6: r.result = a & b;
            5'd2, 5'd7: r.result = a ^ b;
            5'd3, 5'd8: r.result = a | b;
            5'd4:       r.result = ~(a | b);
            5'd16:      r.result = b << a[4:0];
            5'd17:      r.result = b >> a[4:0];
            5'd18:      r.result = 32'($signed(b) >>> a[4:0]);
            5'd19:      r.result = (a[31] != b[31]) ? {31'd0, a[31]} : {31'd0, a < b};
            5'd20:      r.result = {31'd0, a < b};
            default:    r.err = 1'b1;
        endcase
        return r;
    endfunction

    // Reference model of grants and slot occupancy, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_last = 1'b1; m_v0 = 1'b0; m_v1 = 1'b0;
            q0.delete(); q1.delete();
            checks++;
            if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_hold got=%b want=0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
            end
        end else begin
            e0 = req0_valid && (!m_v0 || rsp0_ready);
            e1 = req1_valid && (!m_v1 || rsp1_ready);
            g0 = e0 && (!e1 || m_last);
            g1 = e1 && (!e0 || !m_last);
            checks++;
            if ({req0_ready, req1_ready} !== {g0, g1}) begin
                failures++;
                $display("FAIL grant t=%0t got=%b want=%b", $time, {req0_ready, req1_ready}, {g0, g1});
            end
            checks++;
            if ({rsp0_valid, rsp1_valid} !== {m_v0, m_v1}) begin
                failures++;
                $display("FAIL rsp_valid t=%0t got=%b want=%b", $time, {rsp0_valid, rsp1_valid}, {m_v0, m_v1});
            end
            if (m_v0 && rsp0_ready) begin
                checks++;
                if (q0.size() == 0) begin
                    failures++;
                    $display("FAIL sb0 got=response want=empty_queue_entry");
                end else begin
                    exp_head = q0.pop_front();
                    if ({rsp0_result, rsp0_overflow, rsp0_err} !== exp_head) begin
                        failures++;
                        $display("FAIL sb0 t=%0t got=%h/%b/%b want=%h/%b/%b", $time, rsp0_result, rsp0_overflow,
                                 rsp0_err, exp_head.result, exp_head.ovf, exp_head.err);
                    end
                end
            end
            if (m_v1 && rsp1_ready) begin
                checks++;
                if (q1.size() == 0) begin
                    failures++;
                    $display("FAIL sb1 got=response want=empty_queue_entry");
                end else begin
                    exp_head = q1.pop_front();
                    if ({rsp1_result, rsp1_overflow, rsp1_err} !== exp_head) begin
                        failures++;
                        $display("FAIL sb1 t=%0t got=%h/%b/%b want=%h/%b/%b", $time, rsp1_result, rsp1_overflow,
                                 rsp1_err, exp_head.result, exp_head.ovf, exp_head.err);
                    end
                end
            end
            if (g0) begin
                q0.push_back(model(req0_code, req0_a, req0_b));
                m_v0 = 1'b1;
            end else if (rsp0_ready) m_v0 = 1'b0;
            if (g1) begin
                q1.push_back(model(req1_code, req1_a, req1_b));
                m_v1 = 1'b1;
            end else if (rsp1_ready) m_v1 = 1'b0;
            if (g0 || g1) m_last = g1;
        end
    end

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result,
             rsp0_overflow, rsp1_overflow, rsp0_err, rsp1_err} !== '0) begin
            failures++;
            $display("FAIL reset_values got=%b%b%b%b %h %h want=0000 00000000 00000000",
                     req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp0_result, rsp1_result);
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        idle();
    endtask

    task automatic test_single_add;
        next_cycle();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_code = ALU_ADD; req0_a = 32'h00004012; req0_b = 32'h1000200F;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL add_grant got=%b want=1", req0_ready);
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if ({rsp0_valid, rsp0_result, rsp0_overflow, rsp0_err} !== {1'b1, 32'h10006021, 2'b00}) begin
            failures++;
            $display("FAIL add_rsp got=%b %h %b %b want=1 10006021 0 0", rsp0_valid, rsp0_result, rsp0_overflow, rsp0_err);
        end
    endtask

    task automatic test_overflow;
        next_cycle();
        req1_valid = 1'b1; req1_code = ALU_ADD; req1_a = 32'h40000000; req1_b = 32'h40000000;
        next_cycle();
        idle();
        #1;
        checks++;
        if ({rsp1_valid, rsp1_result, rsp1_overflow, rsp1_err} !== {1'b1, 32'h80000000, 2'b10}) begin
            failures++;
            $display("FAIL overflow got=%b %h %b %b want=1 80000000 1 0", rsp1_valid, rsp1_result, rsp1_overflow, rsp1_err);
        end
    endtask

    task automatic test_tie;
        next_cycle();
        req0_valid = 1'b1; req0_code = ALU_SUB; req0_a = 32'h70F0C0E0; req0_b = 32'h10003054;
        req1_valid = 1'b1; req1_code = ALU_SLT; req1_a = 32'hFF000004; req1_b = 32'h700000FF;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL tie_first got=%b want=10", {req0_ready, req1_ready});
        end
        next_cycle();
        req0_code = ALU_AND; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_result} !== {2'b01, 32'h60F0908C}) begin
            failures++;
            $display("FAIL tie_second got=%b %h want=01 60f0908c", {req0_ready, req1_ready}, rsp0_result);
        end
        next_cycle();
        req1_valid = 1'b0;
        #1;
        checks++;
        if ({req0_ready, rsp1_result} !== {1'b1, 32'h00000001}) begin
            failures++;
            $display("FAIL tie_third got=%b %h want=1 00000001", req0_ready, rsp1_result);
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if (rsp0_result !== 32'h0F0F0000) begin
            failures++;
            $display("FAIL tie_and got=%h want=0f0f0000", rsp0_result);
        end
    endtask

    task automatic test_backpressure;
        next_cycle();
        rsp0_ready = 1'b0;
        req0_valid = 1'b1; req0_code = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_fill got=%b want=1", req0_ready);
        end
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            req0_code = ALU_SUB; req0_a = 32'd9; req0_b = 32'd4;
            req1_valid = 1'b1; req1_code = ALU_XOR; req1_a = 32'(k); req1_b = 32'hA5A5A5A5;
            #1;
            checks++;
            if ({req0_ready, req1_ready, rsp0_valid, rsp0_result} !== {3'b011, 32'd3}) begin
                failures++;
                $display("FAIL bp_hold k=%0d got=%b %h want=011 00000003", k,
                         {req0_ready, req1_ready, rsp0_valid}, rsp0_result);
            end
        end
        next_cycle();
        rsp0_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL bp_release got=%b want=10", {req0_ready, req1_ready});
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if (rsp0_result !== 32'd5) begin
            failures++;
            $display("FAIL bp_result got=%h want=00000005", rsp0_result);
        end
    endtask

    task automatic test_shift_err;
        next_cycle();
        req0_valid = 1'b1; req0_code = ALU_SRA; req0_a = 32'h00000004; req0_b = 32'hFFFFE0FF;
        next_cycle();
        req0_code = 5'd9; req0_a = 32'h40000000; req0_b = 32'h40000000;
        #1;
        checks++;
        if ({rsp0_result, rsp0_err} !== {32'hFFFFFE0F, 1'b0}) begin
            failures++;
            $display("FAIL sra got=%h err=%b want=fffffe0f err=0", rsp0_result, rsp0_err);
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if ({rsp0_valid, rsp0_result, rsp0_overflow, rsp0_err} !== {1'b1, 32'h0, 2'b01}) begin
            failures++;
            $display("FAIL bad_code got=%b %h %b %b want=1 00000000 0 1", rsp0_valid, rsp0_result, rsp0_overflow, rsp0_err);
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 300; i++) begin
            next_cycle();
            req0_valid = ($urandom_range(0, 3) != 0);
            req1_valid = ($urandom_range(0, 3) != 0);
            if (req0_valid) begin
                req0_code = 5'($urandom_range(0, 31)); req0_a = $urandom; req0_b = $urandom;
            end else begin
                req0_code = 'x; req0_a = 'x; req0_b = 'x;
            end
            if (req1_valid) begin
                req1_code = 5'($urandom_range(0, 31)); req1_a = $urandom; req1_b = $urandom;
            end else begin
                req1_code = 'x; req1_a = 'x; req1_b = 'x;
            end
            rsp0_ready = ($urandom_range(0, 9) < 7);
            rsp1_ready = ($urandom_range(0, 9) < 7);
        end
        next_cycle();
        idle();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        repeat (3) next_cycle();
        checks++;
        if ({rsp0_valid, rsp1_valid} !== 2'b00 || q0.size() + q1.size() != 0) begin
            failures++;
            $display("FAIL drain got=%b queued=%0d want=00 queued=0", {rsp0_valid, rsp1_valid}, q0.size() + q1.size());
        end
    endtask

    task automatic test_reset_midop;
        next_cycle();
        rsp1_ready = 1'b0;
        req1_valid = 1'b1; req1_code = ALU_OR; req1_a = 32'h1; req1_b = 32'h2;
        next_cycle();
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_code = ALU_ADD; req0_a = 32'h5; req0_b = 32'h6;
        #1;
        checks++;
        if ({req0_ready, rsp1_valid} !== 2'b11) begin
            failures++;
            $display("FAIL midop_setup got=%b want=11", {req0_ready, rsp1_valid});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready, rsp0_valid, rsp1_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL midop_reset got=%b want=0000", {req0_ready, req1_ready, rsp0_valid, rsp1_valid});
        end
        next_cycle();
        rst_n = 1'b1;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_valid = 1'b1; req0_code = ALU_SUB; req0_a = 32'h70F0C0E0; req0_b = 32'h10003054;
        req1_valid = 1'b1; req1_code = ALU_SLT; req1_a = 32'hFF000004; req1_b = 32'h700000FF;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL midop_tie got=%b want=10", {req0_ready, req1_ready});
        end
        next_cycle();
        req0_valid = 1'b0;
        #1;
        checks++;
        if ({rsp0_valid, rsp0_result, rsp1_valid, req1_ready} !== {1'b1, 32'h60F0908C, 2'b01}) begin
            failures++;
            $display("FAIL midop_after got=%b %h %b %b want=1 60f0908c 0 1", rsp0_valid, rsp0_result, rsp1_valid, req1_ready);
        end
        next_cycle();
        idle();
        #1;
        checks++;
        if ({rsp1_valid, rsp1_result} !== {1'b1, 32'h1}) begin
            failures++;
            $display("FAIL midop_rsp1 got=%b %h want=1 00000001", rsp1_valid, rsp1_result);
        end
        next_cycle();
    endtask

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_code = '0; req1_code = '0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        test_reset();
        test_single_add();
        test_overflow();
        test_tie();
        test_backpressure();
        test_shift_err();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
